// File: rtl/dvfs_pkg.sv
// rtl/dvfs_pkg.sv - shared constants, state encoding and opcode classification for the DVFS governor
package dvfs_pkg;

    // Clock mux select codes; the mux decode depends on these exact values.
    localparam logic [2:0] OPC_FAST = 3'b100;
    localparam logic [2:0] OPC_SLOW = 3'b000;

    // RV32I major opcodes that count as heavy work.
    localparam logic [6:0] RV_OP     = 7'b0110011;
    localparam logic [6:0] RV_OP_IMM = 7'b0010011;
    localparam logic [6:0] RV_LOAD   = 7'b0000011;
    localparam logic [6:0] RV_STORE  = 7'b0100011;

    // Governor FSM encoding; TO_* states are the dwell states after a switch.
    localparam logic [1:0] ST_SLOW    = 2'd0;
    localparam logic [1:0] ST_TO_FAST = 2'd1;
    localparam logic [1:0] ST_FAST    = 2'd2;
    localparam logic [1:0] ST_TO_SLOW = 2'd3;

    // True for the opcodes that make up the heavy instruction class.
    function automatic logic is_heavy_opcode(input logic [6:0] opc);
        return (opc == RV_OP) || (opc == RV_OP_IMM) ||
               (opc == RV_LOAD) || (opc == RV_STORE);
    endfunction

endpackage

// File: rtl/dvfs_activity_window.sv
// rtl/dvfs_activity_window.sv - heavy-instruction counter over fixed observation windows
module dvfs_activity_window #(
    parameter int WINDOW = 64,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk_100,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [6:0]       instr_opcode,
    output logic             win_end,
    output logic [CNT_W-1:0] win_total,
    output logic [CNT_W-1:0] win_count
);
    import dvfs_pkg::*;

    localparam int               WC_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW - 1);

    logic [WC_W-1:0]  wcnt;
    logic [CNT_W-1:0] act;
    logic             heavy;

    assign heavy   = instr_valid && is_heavy_opcode(instr_opcode);
    assign win_end = (wcnt == WC_LAST);

    // The closing cycle's own heavy instruction belongs to the window it closes,
    // so the final total includes it combinationally.
    assign win_total = act + CNT_W'(heavy);

    // Window position and activity counters; the total is latched and act cleared at window end.
    always_ff @(posedge clk_100 or negedge reset) begin
        if (!reset) begin
            wcnt      <= '0;
            act       <= '0;
            win_count <= '0;
        end else if (win_end) begin
            wcnt      <= '0;
            act       <= '0;
            win_count <= win_total;
        end else begin
            wcnt <= wcnt + WC_W'(1);
            act  <= win_total;
        end
    end

endmodule

// File: rtl/dvfs_controller.sv
// rtl/dvfs_controller.sv - workload-driven fast/slow governor driving the glitch-free clock mux select
module dvfs_controller #(
    parameter int WINDOW    = 64,
    parameter int HI_THRESH = 48,
    parameter int LO_THRESH = 16,
    parameter int DWELL     = 16,
    parameter int CNT_W     = $clog2(WINDOW + 1)
) (
    input  logic             clk_100,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [6:0]       instr_opcode,
    input  logic             force_en,
    input  logic             force_fast,
    output logic [2:0]       opcode,
    output logic             fast_mode,
    output logic             busy,
    output logic [CNT_W-1:0] win_count
);
    import dvfs_pkg::*;

    // Dwell counter counts DWELL-1 down to 0, giving DWELL busy cycles.
    localparam int               DW_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]  DW_LOAD = DW_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] HI_C    = CNT_W'(HI_THRESH);
    localparam logic [CNT_W-1:0] LO_C    = CNT_W'(LO_THRESH);

    generate
        if (!(LO_THRESH >= 0 && LO_THRESH < HI_THRESH && HI_THRESH <= WINDOW)) begin : g_bad_thresh
            $error("dvfs_controller: thresholds must satisfy 0 <= LO_THRESH < HI_THRESH <= WINDOW");
        end
        if (DWELL < 1) begin : g_bad_dwell
            $error("dvfs_controller: DWELL must be at least 1");
        end
        if (WINDOW < 2 || CNT_W < $clog2(WINDOW + 1)) begin : g_bad_window
            $error("dvfs_controller: WINDOW must be >= 2 and CNT_W wide enough to hold WINDOW");
        end
    endgenerate

    logic             win_end;
    logic [CNT_W-1:0] win_total;

    logic [1:0]       state_q, state_d;
    logic [DW_W-1:0]  dcnt_q, dcnt_d;
    logic [2:0]       opcode_q;
    logic             fast_q;
    logic             busy_q;
    logic             go_fast, go_slow;
    logic             next_fast, next_busy;

    dvfs_activity_window #(
        .WINDOW (WINDOW),
        .CNT_W  (CNT_W)
    ) u_window (
        .clk_100      (clk_100),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_opcode (instr_opcode),
        .win_end      (win_end),
        .win_total    (win_total),
        .win_count    (win_count)
    );

    // Force overrides the threshold decision entirely while asserted, even when
    // it already matches the current mode.
    assign go_fast = force_en ? force_fast  : (win_end && (win_total >= HI_C));
    assign go_slow = force_en ? !force_fast : (win_end && (win_total <= LO_C));

    // Next-state logic; decisions are only taken in the stable states, so a
    // window end or force seen during dwell is ignored until dwell expires.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            ST_SLOW: begin
                if (go_fast) begin
                    state_d = ST_TO_FAST;
                    dcnt_d  = DW_LOAD;
                end
            end
            ST_FAST: begin
                if (go_slow) begin
                    state_d = ST_TO_SLOW;
                    dcnt_d  = DW_LOAD;
                end
            end
            ST_TO_FAST: begin
                if (dcnt_q == '0) begin
                    state_d = ST_FAST;
                end else begin
                    dcnt_d = dcnt_q - DW_W'(1);
                end
            end
            ST_TO_SLOW: begin
                if (dcnt_q == '0) begin
                    state_d = ST_SLOW;
                end else begin
                    dcnt_d = dcnt_q - DW_W'(1);
                end
            end
            default: begin
                state_d = ST_SLOW;
                dcnt_d  = '0;
            end
        endcase
    end

    assign next_fast = (state_d == ST_FAST) || (state_d == ST_TO_FAST);
    assign next_busy = (state_d == ST_TO_FAST) || (state_d == ST_TO_SLOW);

    // State, dwell counter and mux-facing outputs are all registered so the mux
    // select never sees a combinational path from the instruction stream.
    always_ff @(posedge clk_100 or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_SLOW;
            dcnt_q   <= '0;
            opcode_q <= OPC_SLOW;
            fast_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            opcode_q <= next_fast ? OPC_FAST : OPC_SLOW;
            fast_q   <= next_fast;
            busy_q   <= next_busy;
        end
    end

    assign opcode    = opcode_q;
    assign fast_mode = fast_q;
    assign busy      = busy_q;

endmodule

// File: doc/dvfs_controller.md
# dvfs_controller

Workload-driven frequency governor that sits directly upstream of the glitch-free clock mux and drives its 3-bit `opcode` select. It classifies the retiring RV32I instruction stream over fixed observation windows, applies high/low thresholds with hysteresis, and registers the fast/slow decision. A minimum dwell period after each switch gives the mux handover time to complete before any further change.

## Interface
- `WINDOW`, 64: observation window length in `clk_100` cycles.
- `HI_THRESH`, 48: heavy-instruction count per window at or above which slow→fast.
- `LO_THRESH`, 16: count at or below which fast→slow.
- `DWELL`, 16: cycles `opcode` is held after any switch.
- `CNT_W`, clog2(WINDOW+1): width of count outputs.

- `clk_100` in 1: single clock, free-running 100 MHz source.
- `reset` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: an instruction retires this cycle.
- `instr_opcode` in 7: RV32I opcode field of the retiring instruction.
- `force_en` in 1: software override enable.
- `force_fast` in 1: override target; 1 = fast, 0 = slow.
- `opcode` out 3: to clock mux; 3'b100 = fast, 3'b000 = slow.
- `fast_mode` out 1: 1 while state is FAST or TO_FAST.
- `busy` out 1: 1 during dwell.
- `win_count` out CNT_W: heavy count of the last completed window.

## Operation
- Heavy cycle: `instr_valid` high and `instr_opcode` is one of OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011. All other opcodes count zero.
- Window counter `wcnt` runs 0..WINDOW-1 and wraps. Activity counter `act` increments on heavy cycles.
- Window end is the cycle with `wcnt`==WINDOW-1. Final count = `act` + (heavy this cycle). It is latched into `win_count`, and `act` clears to 0 at the same edge.
- FSM states: SLOW, TO_FAST, FAST, TO_SLOW.
  - SLOW → TO_FAST at window end when count ≥ HI_THRESH.
  - FAST → TO_SLOW at window end when count ≤ LO_THRESH.
  - TO_x → x when the dwell counter expires.
- `opcode` encoding: 3'b100 in TO_FAST/FAST, 3'b000 in SLOW/TO_SLOW. It is a registered output with no combinational path from inputs.
- Force: in SLOW or FAST with `force_en`=1 and `force_fast` ≠ current mode, the block transitions on the next edge regardless of window position. While `force_en`=1, threshold decisions are suppressed.
- Windows and `win_count` keep running in every state, including dwell and force.
- Parameter legality: 0 ≤ LO_THRESH < HI_THRESH ≤ WINDOW, and DWELL ≥ 1. Enforce with elaboration-time checks.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) values:
  - state SLOW, `opcode` 3'b000, `fast_mode` 0, `busy` 0, `win_count` 0.
  - `wcnt`, `act` and the dwell counter all 0.
- Threshold latency: `opcode` changes at the edge that closes window-end cycle WINDOW-1. The first window after reset ends at the edge closing cycle 63.
- Force latency: one edge from `force_en` sampled high in a stable state.
- Dwell: `busy` rises with the `opcode` change and stays high for exactly DWELL cycles. On the following edge the state becomes stable and `busy` falls.
- During dwell, window-end decisions are discarded (the count is still latched) and force is held pending. A pending force is evaluated on the first stable cycle.
- Window end and `force_en` in the same cycle: force wins.
- Reset mid-dwell: immediate return to SLOW / 3'b000, all counters cleared.
- `win_count` saturation is impossible by construction (CNT_W holds WINDOW).

## Structure
- Shared package `dvfs_pkg`:
  - constants OPC_FAST = 3'b100 and OPC_SLOW = 3'b000, which the mux decode relies on;
  - RV32I opcode constants for OP, OP-IMM, LOAD and STORE;
  - FSM state encoding.
- One sub-module, `dvfs_activity_window`: heavy classification, `wcnt`/`act` counters, and the `win_end`/`win_count` outputs.
- The top level holds the FSM, dwell counter and output registers.

## Test plan
- Reset with `reset`=0 and random inputs → `opcode`=000, `busy`=0, `win_count`=0. After release, idle stimulus keeps `opcode`=000 indefinitely.
- 48 heavy (OP) cycles in the first 64 → `opcode`=100 at the edge closing cycle 63; `win_count`=48; `busy` high exactly 16 cycles. With 47 heavy, `opcode` stays 000 and `win_count`=47.
- In FAST: a window with 17 heavy → stays 100; then a window with 16 heavy → 000 at window end; then a window with 0 heavy and valid JAL-only traffic → remains 000.
- Boundary heavy on the last window cycle: 47 heavy plus a LOAD at `wcnt`=63 → count 48 and switch to fast; that LOAD does not appear in the next window.
- Force: `force_en`=1, `force_fast`=1 in SLOW at `wcnt`=10 → `opcode`=100 next edge. `force_fast`=0 asserted during dwell → switch to 000 on the first cycle after dwell ends. A window reaching 64 heavy while forced slow → no switch.
- Reset pulse at dwell cycle 5 of TO_FAST → `opcode`=000 and `busy`=0 asynchronously; the next window starts counting from `wcnt`=0.
